registrador_universal: RTL and testbench
========================================

# registrador_universal

Parametrised universal register, the next generation of the team's fixed 4-bit parallel register. It supports parallel load, clear, logical, rotate and arithmetic shifts by a programmable amount, and a serial in/out path. Multi-position shifts run one position per clock under a small state machine with busy/done status. It sits wherever the design needs a configurable storage, shift or serialisation stage.

## Interface
- WIDTH, 4: register width in bits; must be 2 or more.
- RESET_VALUE, 0: value loaded into q on reset (WIDTH bits).
- CNT_W (localparam): $clog2(WIDTH)+1, the width of amount and of the internal counter.

- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  3  operation, latched at start.
- amount  in  CNT_W  number of shift positions.
- d  in  WIDTH  parallel load data.
- serial_in  in  1  fill bit for logical shifts; sampled live on every shift edge.
- q  out  WIDTH  register contents.
- serial_out  out  1  last bit shifted or rotated out.
- busy  out  1  high while in SHIFT state.
- done  out  1  one-cycle completion pulse.
- parity  out  1  present only with the macro (see Configuration).

## Operation
- Mode encodings:
  - 000 HOLD
  - 001 LOAD (q <= d)
  - 010 SHL, serial_in into LSB
  - 011 SHR, serial_in into MSB
  - 100 ROL
  - 101 ROR
  - 110 ASR, MSB replicated
  - 111 CLEAR (q <= 0)
- The FSM has two states, IDLE and SHIFT.
- In IDLE with start=1:
  - HOLD, LOAD, CLEAR: complete in that edge; state stays IDLE.
  - Shift modes with amount=0: q unchanged; treated as complete.
  - Shift modes with amount=1: one shift; state stays IDLE.
  - Shift modes with amount=N≥2: first shift on this edge; remaining <= N-1; go to SHIFT.
- SHIFT: one shift per edge using the latched mode. When remaining reaches 1, the final shift occurs and the FSM returns to IDLE.
- start asserted while busy is ignored; no queuing.
- Changes to mode, amount or d while busy have no effect.
- amount is not saturated. Every position is a real step, so a rotate by N equals a rotate by N mod WIDTH, and SHL/SHR by N≥WIDTH fills q entirely with serial_in.
- serial_out updates only on shift edges:
  - Logical and rotate left: the outgoing MSB.
  - Right modes: the outgoing LSB.
  - Otherwise it holds its value.

## Timing
- Reset (reset_n=0, immediate, independent of clock):
  - q=RESET_VALUE, serial_out=0, busy=0, done=0, state IDLE.
  - The counter is cleared.
  - Reset mid-shift aborts the operation with no done pulse.
- Start accepted at edge k:
  - Single-cycle operations (including amount 0 or 1): q valid after edge k; done=1 for the cycle after edge k; busy stays 0.
  - Shift by N≥2: shifts at edges k … k+N-1.
  - busy=1 from after edge k until edge k+N-1, which is N-1 cycles.
  - done=1 for the single cycle after edge k+N-1.
- A new start is accepted in the cycle done is high, so back-to-back operations have no bubble.
- done is registered; busy is decoded from the state register.

## Configuration
- REGISTRADOR_UNIVERSAL_PARITY_EN:
  - Defined: adds the parity output, equal to the XOR reduction of q. It is combinational from q and follows q, including during reset.
  - Undefined: the parity port and its logic are absent. All other behaviour is identical.

## Structure
- Package registrador_pkg holds:
  - The 3-bit mode constants/enum (MODE_HOLD … MODE_CLEAR).
  - The FSM state type (ST_IDLE, ST_SHIFT).
- Sub-module registrador_shift_step: combinational single-position shifter.
  - Inputs: q, mode, serial_in.
  - Outputs: next q and the outgoing bit.
  - Instantiated once; the top holds the state, the counter and the registers.

## Test plan
- Reset: assert reset_n=0 mid-cycle -> immediately q=0000, busy=0, done=0, serial_out=0.
- LOAD: d=1011, start -> after one edge q=1011, done high for 1 cycle, busy never high.
- SHL from q=1011, N=2, serial_in=1 -> q=0111 then 1111. busy for 1 cycle, then done; serial_out=0.
- ROR from q=1011, N=5 -> final q=1101 and serial_out=1. busy for 4 cycles; a start pulse during busy is ignored; exactly one done pulse.
- ASR from q=1000, N=3 -> q=1100, 1110, 1111; serial_out=0. Then SHR with amount=0 -> q unchanged and done pulses.
- Reset mid-operation: assert reset_n during ROL N=6 -> q=0000 and no done. With REGISTRADOR_UNIVERSAL_PARITY_EN, LOAD 1011 -> parity=1, then LOAD 1001 -> parity=0.

Source files
------------

// File: rtl/registrador_pkg.sv
// -----------------------------------------------------------------------------
// registrador_pkg
// Shared definitions for the universal register: the 3-bit operation codes,
// the two-state FSM encoding and a helper that tells shift-type modes apart
// from single-cycle modes.
// Optional feature macro used by the top: REGISTRADOR_UNIVERSAL_PARITY_EN.
// -----------------------------------------------------------------------------
package registrador_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD  = 3'b000;
    localparam mode_t MODE_LOAD  = 3'b001;
    localparam mode_t MODE_SHL   = 3'b010;
    localparam mode_t MODE_SHR   = 3'b011;
    localparam mode_t MODE_ROL   = 3'b100;
    localparam mode_t MODE_ROR   = 3'b101;
    localparam mode_t MODE_ASR   = 3'b110;
    localparam mode_t MODE_CLEAR = 3'b111;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // SHL, SHR, ROL, ROR and ASR occupy the contiguous codes 010..110.
    function automatic logic is_shift_mode(input mode_t m);
        return (m >= MODE_SHL) && (m <= MODE_ASR);
    endfunction

endpackage

// File: rtl/registrador_shift_step.sv
// -----------------------------------------------------------------------------
// registrador_shift_step
// Combinational single-position shifter used by the universal register.
// Ports:
//   q         in  WIDTH  current register contents
//   mode      in  3      operation code (only shift codes move data)
//   serial_in in  1      fill bit for the logical shifts
//   q_next    out WIDTH  contents after one position
//   out_bit   out 1      bit leaving the register on this step
// Non-shift codes pass q through with out_bit = 0; the caller never uses
// out_bit in that case.
// -----------------------------------------------------------------------------
module registrador_shift_step
    import registrador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (mode)
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], serial_in};
                out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {serial_in, q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ROL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            MODE_ASR: begin
                q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
                out_bit = q[0];
            end
            default: begin
                q_next  = q;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/registrador_universal.sv
// -----------------------------------------------------------------------------
// registrador_universal
// Parametrised universal register: parallel load, clear, hold, logical /
// rotate / arithmetic shifts by a programmable amount (one position per
// clock) and a serial in/out path, with busy/done status.
// Ports:
//   clock      in  1      rising-edge clock
//   reset_n    in  1      asynchronous active-low reset
//   start      in  1      operation request, sampled only in IDLE
//   mode       in  3      operation code, latched at start
//   amount     in  CNT_W  number of shift positions
//   d          in  WIDTH  parallel load data
//   serial_in  in  1      fill bit for logical shifts (sampled every shift)
//   q          out WIDTH  register contents
//   serial_out out 1      last bit shifted or rotated out
//   busy       out 1      high while a multi-position shift is in progress
//   done       out 1      one-cycle completion pulse
//   parity     out 1      XOR of q; only when REGISTRADOR_UNIVERSAL_PARITY_EN
//                         is defined
// -----------------------------------------------------------------------------
module registrador_universal
    import registrador_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
    ,
    output logic             parity
`endif
);

    state_t           state;
    mode_t            mode_lat;
    logic [CNT_W-1:0] remaining;
    mode_t            step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // The first shift happens on the accepting edge, before mode is latched,
    // so the shifter sees the live mode in IDLE and the latched one in SHIFT.
    assign step_mode = (state == ST_SHIFT) ? mode_lat : mode;

    registrador_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .q        (q),
        .mode     (step_mode),
        .serial_in(serial_in),
        .q_next   (step_q),
        .out_bit  (step_out)
    );

    assign busy = (state == ST_SHIFT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q          <= RESET_VALUE;
            serial_out <= 1'b0;
            done       <= 1'b0;
            state      <= ST_IDLE;
            remaining  <= '0;
            mode_lat   <= MODE_HOLD;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    if (is_shift_mode(mode)) begin
                        if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            q          <= step_q;
                            serial_out <= step_out;
                            if (amount == CNT_W'(1)) begin
                                done <= 1'b1;
                            end else begin
                                remaining <= amount - CNT_W'(1);
                                mode_lat  <= mode;
                                state     <= ST_SHIFT;
                            end
                        end
                    end else begin
                        case (mode)
                            MODE_LOAD:  q <= d;
                            MODE_CLEAR: q <= '0;
                            default:    q <= q;
                        endcase
                        done <= 1'b1;
                    end
                end
            end else begin
                q          <= step_q;
                serial_out <= step_out;
                // remaining counts the shifts still owed including this one.
                if (remaining == CNT_W'(1)) begin
                    remaining <= '0;
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end else begin
                    remaining <= remaining - CNT_W'(1);
                end
            end
        end
    end

`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: tb/tb_registrador_universal.sv
// -----------------------------------------------------------------------------
// tb_registrador_universal
// Self-checking bench for registrador_universal (WIDTH=4, RESET_VALUE=0).
// Each scenario pushes the expected {q, busy, done, serial_out} for every
// cycle after the accepting edge into a queue and pops/compares one entry per
// clock, sampling 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_registrador_universal;
    import registrador_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             so;
    } obs_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] d;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;
`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
    logic             parity;
`endif

    int   total_cnt = 0;
    int   pass_cnt  = 0;
    obs_t sb[$];

    registrador_universal #(
        .WIDTH(WIDTH),
        .RESET_VALUE(4'b0000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .amount    (amount),
        .d         (d),
        .serial_in (serial_in),
        .q         (q),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 clock = ~clock;

    function automatic obs_t ex(input logic [3:0] qq, input logic b,
                                input logic dn, input logic s);
        return {qq, b, dn, s};
    endfunction

    function automatic obs_t observe();
        return {q, busy, done, serial_out};
    endfunction

    // Presents a request at the falling edge so it is taken on the next rise.
    task automatic start_op(input logic [2:0] m, input logic [CNT_W-1:0] amt,
                            input logic [3:0] dv, input logic sin);
        @(negedge clock);
        mode      = m;
        amount    = amt;
        d         = dv;
        serial_in = sin;
        start     = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; mode = MODE_HOLD; amount = '0;
        d = '0; serial_in = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        start_op(MODE_LOAD, '0, 4'b0110, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++; if (q !== 4'b0000) $display("FAIL reset_q: got %b want 0000", q); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (serial_out !== 1'b0) $display("FAIL reset_so: got %b want 0", serial_out); else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_load;
        obs_t e;
        start_op(MODE_LOAD, '0, 4'b1011, 1'b0);
        sb.push_back(ex(4'b1011, 0, 1, 0));
        sb.push_back(ex(4'b1011, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL load: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_shl;
        obs_t e;
        start_op(MODE_SHL, CNT_W'(2), 4'b0000, 1'b1);
        sb.push_back(ex(4'b0111, 1, 0, 1));
        sb.push_back(ex(4'b1111, 0, 1, 0));
        sb.push_back(ex(4'b1111, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL shl: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_ror;
        obs_t e;
        int   dcnt = 0;
        start_op(MODE_LOAD, '0, 4'b1011, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        total_cnt++;
        if (observe() !== ex(4'b1011, 0, 1, 0)) $display("FAIL ror_load: got %b want %b", observe(), ex(4'b1011, 0, 1, 0));
        else pass_cnt++;
        start_op(MODE_ROR, CNT_W'(5), 4'b0000, 1'b0);
        sb.push_back(ex(4'b1101, 1, 0, 1));
        sb.push_back(ex(4'b1110, 1, 0, 1));
        sb.push_back(ex(4'b0111, 1, 0, 0));
        sb.push_back(ex(4'b1011, 1, 0, 1));
        sb.push_back(ex(4'b1101, 0, 1, 1));
        sb.push_back(ex(4'b1101, 0, 0, 1));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(posedge clock); #1;
            // A LOAD request arriving mid-shift must be dropped.
            start = (i == 1);
            if (i == 1) begin
                mode = MODE_LOAD; d = 4'b0000; amount = '0;
            end
            if (done === 1'b1) dcnt++;
            total_cnt++;
            if (observe() !== e) $display("FAIL ror: step %0d got %b want %b", i, observe(), e);
            else pass_cnt++;
        end
        total_cnt++;
        if (dcnt != 1) $display("FAIL ror_done_count: got %0d want 1", dcnt);
        else pass_cnt++;
    endtask

    task automatic test_asr_and_zero;
        obs_t e;
        start_op(MODE_LOAD, '0, 4'b1000, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        total_cnt++;
        if (observe() !== ex(4'b1000, 0, 1, 1)) $display("FAIL asr_load: got %b want %b", observe(), ex(4'b1000, 0, 1, 1));
        else pass_cnt++;
        start_op(MODE_ASR, CNT_W'(3), 4'b0000, 1'b0);
        sb.push_back(ex(4'b1100, 1, 0, 0));
        sb.push_back(ex(4'b1110, 1, 0, 0));
        sb.push_back(ex(4'b1111, 0, 1, 0));
        sb.push_back(ex(4'b1111, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL asr: got %b want %b", observe(), e);
            else pass_cnt++;
        end
        start_op(MODE_SHR, '0, 4'b0000, 1'b1);
        sb.push_back(ex(4'b1111, 0, 1, 0));
        sb.push_back(ex(4'b1111, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL shr_zero: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_clear_hold;
        obs_t e;
        start_op(MODE_HOLD, CNT_W'(3), 4'b0101, 1'b0);
        sb.push_back(ex(4'b1111, 0, 1, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL hold: got %b want %b", observe(), e);
            else pass_cnt++;
        end
        start_op(MODE_CLEAR, '0, 4'b0101, 1'b0);
        sb.push_back(ex(4'b0000, 0, 1, 0));
        sb.push_back(ex(4'b0000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL clear: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        obs_t e;
        start_op(MODE_LOAD, '0, 4'b0001, 1'b0);
        sb.push_back(ex(4'b0001, 0, 1, 0));
        sb.push_back(ex(4'b0010, 0, 1, 0));
        sb.push_back(ex(4'b0010, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(posedge clock); #1;
            // Keep start high into the done cycle with a new ROL-by-1 request.
            start = (i == 0);
            if (i == 0) begin
                mode = MODE_ROL; amount = CNT_W'(1);
            end
            total_cnt++;
            if (observe() !== e) $display("FAIL back_to_back: step %0d got %b want %b", i, observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_shl_overflow;
        obs_t e;
        start_op(MODE_SHL, CNT_W'(5), 4'b0000, 1'b1);
        sb.push_back(ex(4'b0101, 1, 0, 0));
        sb.push_back(ex(4'b1011, 1, 0, 0));
        sb.push_back(ex(4'b0111, 1, 0, 1));
        sb.push_back(ex(4'b1111, 1, 0, 0));
        sb.push_back(ex(4'b1111, 0, 1, 1));
        sb.push_back(ex(4'b1111, 0, 0, 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL shl_overflow: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop;
        obs_t e;
        start_op(MODE_LOAD, '0, 4'b0011, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        start_op(MODE_ROL, CNT_W'(6), 4'b0000, 1'b0);
        sb.push_back(ex(4'b0110, 1, 0, 0));
        sb.push_back(ex(4'b1100, 1, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1; start = 1'b0;
            total_cnt++;
            if (observe() !== e) $display("FAIL rol_pre_reset: got %b want %b", observe(), e);
            else pass_cnt++;
        end
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (observe() !== ex(4'b0000, 0, 0, 0)) $display("FAIL midop_reset: got %b want %b", observe(), ex(4'b0000, 0, 0, 0));
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (8) sb.push_back(ex(4'b0000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clock); #1;
            total_cnt++;
            if (observe() !== e) $display("FAIL midop_after: got %b want %b", observe(), e);
            else pass_cnt++;
        end
    endtask

`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
    task automatic test_parity;
        start_op(MODE_LOAD, '0, 4'b1011, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        total_cnt++;
        if (parity !== 1'b1) $display("FAIL parity_1011: got %b want 1", parity);
        else pass_cnt++;
        start_op(MODE_LOAD, '0, 4'b1001, 1'b0);
        @(posedge clock); #1; start = 1'b0;
        total_cnt++;
        if (parity !== 1'b0) $display("FAIL parity_1001: got %b want 0", parity);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_ror();
        test_asr_and_zero();
        test_clear_hold();
        test_back_to_back();
        test_shl_overflow();
        test_reset_midop();
`ifdef REGISTRADOR_UNIVERSAL_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
